// File: rtl/regfile_ctrl_if.sv
// Bundle of the instruction, register-file and OUT-result signals of regfile_ctrl.
// slave is the controller side; master is the environment (source, register file, consumer).
interface regfile_ctrl_if;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [1:0] selDin;
   logic [1:0] selAout;
   logic [1:0] selBout;
   logic       write;
   logic [7:0] data;
   logic [7:0] regoutA;
   logic [7:0] regoutB;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] icount;

   modport slave (
      input  instr, instr_valid, regoutA, regoutB, out_ready,
      output instr_ready, selDin, selAout, selBout, write, data,
             out_data, out_valid, icount
   );

   modport master (
      output instr, instr_valid, regoutA, regoutB, out_ready,
      input  instr_ready, selDin, selAout, selBout, write, data,
             out_data, out_valid, icount
   );
endinterface

// File: rtl/regfile_ctrl.sv
// Multi-cycle sequencer for a 4x8 register file: decodes ADD/SUB/LI/OUT bytes,
// drives read selects and a one-cycle write pulse, and returns OUT results.
module regfile_ctrl (
   input  logic                 clk,
   input  logic                 rst,
   regfile_ctrl_if.slave        bus,
   output logic [2:0]           dbg_state_o
);

   // Handshakes: a byte moves on instr when instr_valid && instr_ready at a rising
   // edge; a result moves on out_data when out_valid && out_ready at a rising edge.
   typedef enum logic [2:0] {IDLE, IMM, READ, WB, OUTW} state_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LI  = 2'b10;

   state_e     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [1:0] rd_q, rd_d;
   logic [1:0] seld_q, seld_d;
   logic [1:0] sela_q, sela_d;
   logic [1:0] selb_q, selb_d;
   logic       write_q, write_d;
   logic [7:0] data_q, data_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] icount_q, icount_d;
   logic       ready_q, ready_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= 2'd0;
         rd_q        <= 2'd0;
         seld_q      <= 2'd0;
         sela_q      <= 2'd0;
         selb_q      <= 2'd0;
         write_q     <= 1'b0;
         data_q      <= 8'd0;
         out_data_q  <= 8'd0;
         out_valid_q <= 1'b0;
         icount_q    <= 8'd0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         seld_q      <= seld_d;
         sela_q      <= sela_d;
         selb_q      <= selb_d;
         write_q     <= write_d;
         data_q      <= data_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         icount_q    <= icount_d;
         ready_q     <= ready_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      seld_d      = seld_q;
      sela_d      = sela_q;
      selb_d      = selb_q;
      write_d     = 1'b0;
      data_d      = data_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      icount_d    = icount_q;
      case (state_q)
         IDLE: begin
            if (bus.instr_valid) begin
               op_d    = bus.instr[7:6];
               rd_d    = bus.instr[5:4];
               sela_d  = bus.instr[3:2];
               selb_d  = bus.instr[1:0];
               state_d = (bus.instr[7:6] == OP_LI) ? IMM : READ;
            end
         end
         IMM: begin
            if (bus.instr_valid) begin
               data_d  = bus.instr;
               seld_d  = rd_q;
               write_d = 1'b1;
               state_d = WB;
            end
         end
         READ: begin
            // Selects were loaded at accept, so regoutA/B are settled by now.
            if (op_q == OP_ADD || op_q == OP_SUB) begin
               data_d  = (op_q == OP_SUB) ? (bus.regoutA - bus.regoutB)
                                          : (bus.regoutA + bus.regoutB);
               seld_d  = rd_q;
               write_d = 1'b1;
               state_d = WB;
            end else begin
               out_data_d  = bus.regoutA;
               out_valid_d = 1'b1;
               state_d     = OUTW;
            end
         end
         WB: begin
            icount_d = icount_q + 8'd1;
            state_d  = IDLE;
         end
         OUTW: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               icount_d    = icount_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE) || (state_d == IMM);
   end

   assign bus.instr_ready = ready_q;
   assign bus.selDin      = seld_q;
   assign bus.selAout     = sela_q;
   assign bus.selBout     = selb_q;
   assign bus.write       = write_q;
   assign bus.data        = data_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.icount      = icount_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: register-file model, directed vector table, corner sequences
// and randomized instructions scored against an architectural model.
module tb_regfile_ctrl;

   logic       clk;
   logic       rst;
   logic [2:0] dbg_state;
   regfile_ctrl_if bus ();

   regfile_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: combinational reads, write captured while write is high.
   logic [7:0] rf [4];
   assign bus.regoutA = rf[bus.selAout];
   assign bus.regoutB = rf[bus.selBout];
   always @(posedge clk) if (bus.write) rf[bus.selDin] <= bus.data;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q [$];
   logic [7:0] out_q [$];
   logic [7:0] model_rf [4];
   logic [7:0] icount_m;
   logic       rnd_ready;

   logic       prev_write, prev_ov, prev_acc, prev_rst;
   logic [7:0] prev_od;

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic [9:0] exp_wr;
      logic       is_out;
      logic [7:0] exp_out;
      logic [7:0] exp_icount;
   } vec_t;
   vec_t vecs [7];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural effect of one instruction; optionally queues the expected bus activity.
   task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic push);
      logic [1:0] rd, rs, rt;
      logic [7:0] v;
      rd = b0[5:4]; rs = b0[3:2]; rt = b0[1:0];
      case (b0[7:6])
         2'b00: v = model_rf[rs] + model_rf[rt];
         2'b01: v = model_rf[rs] - model_rf[rt];
         2'b10: v = b1;
         default: v = model_rf[rs];
      endcase
      if (b0[7:6] == 2'b11) begin
         if (push) out_q.push_back(v);
      end else begin
         model_rf[rd] = v;
         if (push) exp_q.push_back({rd, v});
      end
      icount_m = icount_m + 8'd1;
   endtask

   task automatic mon_check();
      logic [9:0] e;
      logic [7:0] o;
      if (bus.write) begin
         chk("write_single_cycle", {15'd0, prev_write}, 16'd0);
         if (exp_q.size() == 0) chk("unexpected_write", {6'd0, bus.selDin, bus.data}, 16'hFFFF);
         else begin
            e = exp_q.pop_front();
            chk("write_sel_data", {6'd0, bus.selDin, bus.data}, {6'd0, e});
         end
      end
      if (prev_ov && !prev_acc && !prev_rst) begin
         chk("out_valid_held", {15'd0, bus.out_valid}, 16'd1);
         chk("out_data_held", {8'd0, bus.out_data}, {8'd0, prev_od});
      end
      if (bus.out_valid && !prev_ov) begin
         if (out_q.size() == 0) chk("unexpected_out", {8'd0, bus.out_data}, 16'hFFFF);
         else begin
            o = out_q.pop_front();
            chk("out_data", {8'd0, bus.out_data}, {8'd0, o});
         end
      end
      prev_write = bus.write;
      prev_ov    = bus.out_valid;
      prev_acc   = bus.out_valid && bus.out_ready;
      prev_od    = bus.out_data;
      prev_rst   = rst;
   endtask

   task automatic to_neg();
      @(negedge clk);
      mon_check();
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic step();
      to_neg();
      to_pos();
   endtask

   // Presents a byte and returns just after the edge that transfers it; valid stays high.
   task automatic send_byte(input logic [7:0] b);
      logic ok;
      bus.instr       = b;
      bus.instr_valid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         to_neg();
         ok = bus.instr_ready;
         to_pos();
         if (ok) return;
      end
      chk("send_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_idle();
      logic ok;
      for (int n = 0; n < 200; n++) begin
         to_neg();
         ok = bus.instr_ready && !bus.out_valid;
         to_pos();
         if (ok) return;
      end
      chk("idle_timeout", 16'd0, 16'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.instr_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      icount_m = 8'd0;
   endtask

   initial begin
      logic [7:0] b0, b1;
      rst = 1'b1;
      bus.instr = 8'd0;
      bus.instr_valid = 1'b0;
      bus.out_ready = 1'b1;
      rnd_ready = 1'b0;
      prev_write = 1'b0; prev_ov = 1'b0; prev_acc = 1'b0; prev_rst = 1'b1; prev_od = 8'd0;
      icount_m = 8'd0;

      vecs[0] = '{8'h90, 8'h05, 10'h105, 1'b0, 8'h00, 8'd1};
      vecs[1] = '{8'hA0, 8'h03, 10'h203, 1'b0, 8'h00, 8'd2};
      vecs[2] = '{8'h36, 8'h00, 10'h308, 1'b0, 8'h00, 8'd3};
      vecs[3] = '{8'h49, 8'h00, 10'h0FE, 1'b0, 8'h00, 8'd4};
      vecs[4] = '{8'hCC, 8'h00, 10'h000, 1'b1, 8'h08, 8'd5};
      vecs[5] = '{8'hB0, 8'hAA, 10'h3AA, 1'b0, 8'h00, 8'd6};
      vecs[6] = '{8'h1F, 8'h00, 10'h154, 1'b0, 8'h00, 8'd7};

      #1;
      do_reset();
      to_neg();
      chk("rst_instr_ready", {15'd0, bus.instr_ready}, 16'd1);
      chk("rst_write", {15'd0, bus.write}, 16'd0);
      chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("rst_sels", {10'd0, bus.selDin, bus.selAout, bus.selBout}, 16'd0);
      chk("rst_data", {bus.data, bus.out_data}, 16'd0);
      chk("rst_icount", {8'd0, bus.icount}, 16'd0);
      to_pos();

      // Directed table.
      foreach (vecs[i]) begin
         if (vecs[i].is_out) out_q.push_back(vecs[i].exp_out);
         else exp_q.push_back(vecs[i].exp_wr);
         model_apply(vecs[i].b0, vecs[i].b1, 1'b0);
         send_byte(vecs[i].b0);
         if (vecs[i].b0[7:6] == 2'b10) send_byte(vecs[i].b1);
         bus.instr_valid = 1'b0;
         wait_idle();
         chk("table_icount", {8'd0, bus.icount}, {8'd0, vecs[i].exp_icount});
      end

      // OUT held off by the consumer for four cycles.
      bus.out_ready = 1'b0;
      model_apply(8'hCC, 8'h00, 1'b1);
      send_byte(8'hCC);
      bus.instr_valid = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         to_neg();
         chk("stall_out_valid", {15'd0, bus.out_valid}, 16'd1);
         chk("stall_out_data", {8'd0, bus.out_data}, {8'd0, model_rf[3]});
         chk("stall_instr_ready", {15'd0, bus.instr_ready}, 16'd0);
         chk("stall_selA", {14'd0, bus.selAout}, 16'd3);
         to_pos();
      end
      bus.out_ready = 1'b1;
      step();
      to_neg();
      chk("stall_release_ready", {15'd0, bus.instr_ready}, 16'd1);
      chk("stall_release_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("stall_icount", {8'd0, bus.icount}, {8'd0, icount_m});
      to_pos();

      // Reset while waiting for an LI immediate.
      send_byte(8'h90);
      bus.instr_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      icount_m = 8'd0;
      to_neg();
      chk("imm_rst_write", {15'd0, bus.write}, 16'd0);
      chk("imm_rst_icount", {8'd0, bus.icount}, 16'd0);
      chk("imm_rst_ready", {15'd0, bus.instr_ready}, 16'd1);
      to_pos();
      model_apply(8'h05, 8'h00, 1'b1);
      send_byte(8'h05);
      bus.instr_valid = 1'b0;
      wait_idle();
      chk("after_rst_icount", {8'd0, bus.icount}, 16'd1);
      chk("after_rst_r0", {8'd0, rf[0]}, {8'd0, model_rf[1] + model_rf[1]});

      // Reset landing on the write-back cycle.
      model_apply(8'h36, 8'h00, 1'b1);
      send_byte(8'h36);
      bus.instr_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      icount_m = 8'd0;
      to_neg();
      chk("wb_rst_write", {15'd0, bus.write}, 16'd0);
      chk("wb_rst_icount", {8'd0, bus.icount}, 16'd0);
      to_pos();

      // 256 back-to-back LIs wrap icount.
      for (int i = 0; i < 256; i++) begin
         b0 = {2'b10, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
         b1 = 8'($urandom_range(0, 255));
         model_apply(b0, b1, 1'b1);
         send_byte(b0);
         send_byte(b1);
      end
      bus.instr_valid = 1'b0;
      wait_idle();
      chk("li256_icount", {8'd0, bus.icount}, 16'd0);

      // Randomized mix with random gaps and consumer backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         b0 = 8'($urandom_range(0, 255));
         b1 = 8'($urandom_range(0, 255));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
         model_apply(b0, b1, 1'b1);
         send_byte(b0);
         if (b0[7:6] == 2'b10) send_byte(b1);
         bus.instr_valid = 1'b0;
         wait_idle();
         chk("rand_icount", {8'd0, bus.icount}, {8'd0, icount_m});
      end
      rnd_ready = 1'b0;
      bus.out_ready = 1'b1;
      for (int r = 0; r < 4; r++) chk("final_rf", {8'd0, rf[r]}, {8'd0, model_rf[r]});
      step();
      step();
      chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
      chk("out_q_drained", 16'(out_q.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
